// File: rtl/rx_dram_write_ctrl.sv
// RX buffer to DRAM write sequencer: pops 16-bit words from the RX buffer, packs four per
// 64-bit word and issues single-beat DRAM writes into a circular address region.
module rx_dram_write_ctrl #(
  parameter int ADDR_W       = 25,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 4096,
  parameter int TIMEOUT      = 1023
) (
  input  logic              DRAM_RD_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              Buffer_Data_Ready,
  input  logic              RX_Buffer_empty,
  input  logic [15:0]       Buffer_RD_Data,
  output logic              DRAM_RD_req,
  output logic [ADDR_W-1:0] dram_address,
  output logic [63:0]       dram_writedata,
  output logic [7:0]        dram_byteenable,
  output logic              dram_write,
  input  logic              dram_waitrequest,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              wr_timeout_err
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(BASE_ADDR + REGION_WORDS - 1);
  localparam int                TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_r;
  logic [2:0]      lane_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            partial_r;

  function automatic logic [7:0] lane_byteenable(input logic [2:0] lanes);
    case (lanes)
      3'd1:    return 8'h03;
      3'd2:    return 8'h0F;
      3'd3:    return 8'h3F;
      3'd4:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (a == LAST_A) begin
      return BASE_A;
    end else begin
      return a + ADDR_W'(1);
    end
  endfunction

  // Pop request is decoded from the POP state so it can never fire against an empty buffer
  // and lasts exactly the one POP cycle before CAPTURE.
  assign DRAM_RD_req = (state_r == S_POP) && !RX_Buffer_empty;

  // Sequencer: state, pack register (driven out as dram_writedata), address and status.
  always_ff @(posedge DRAM_RD_clk) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      lane_r          <= 3'd0;
      to_cnt_r        <= '0;
      partial_r       <= 1'b0;
      dram_address    <= BASE_A;
      dram_writedata  <= 64'd0;
      dram_byteenable <= 8'h00;
      dram_write      <= 1'b0;
      frame_done      <= 1'b0;
      frame_count     <= 16'd0;
      busy            <= 1'b0;
      wr_timeout_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (enable && Buffer_Data_Ready && !RX_Buffer_empty) begin
            state_r <= S_POP;
            busy    <= 1'b1;
          end
        end
        S_POP: begin
          if (RX_Buffer_empty) begin
            if (lane_r == 3'd0) begin
              state_r     <= S_DONE;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              state_r         <= S_WRITE;
              dram_write      <= 1'b1;
              dram_byteenable <= lane_byteenable(lane_r);
              partial_r       <= 1'b1;
            end
          end else begin
            state_r <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          dram_writedata[{lane_r[1:0], 4'b0000} +: 16] <= Buffer_RD_Data;
          lane_r <= lane_r + 3'd1;
          if (lane_r == 3'd3) begin
            state_r         <= S_WRITE;
            dram_write      <= 1'b1;
            dram_byteenable <= 8'hFF;
            partial_r       <= 1'b0;
          end else begin
            state_r <= S_POP;
          end
        end
        S_WRITE: begin
          if (!dram_waitrequest) begin
            dram_write      <= 1'b0;
            dram_address    <= next_addr(dram_address);
            dram_writedata  <= 64'd0;
            dram_byteenable <= 8'h00;
            lane_r          <= 3'd0;
            to_cnt_r        <= '0;
            if (partial_r) begin
              state_r     <= S_DONE;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              state_r <= S_POP;
            end
          end else begin
            // Stall: count towards the timeout but keep the request up.
            if (to_cnt_r != TO_LIMIT) begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (to_cnt_r >= TO_LIMIT - TO_W'(1)) begin
              wr_timeout_err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r    <= S_IDLE;
          busy       <= 1'b0;
          dram_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
